if_stage_fetch_unit: RTL and testbench

- Instruction-fetch stage for the RV32IM pipeline. Sits directly upstream of the IF/ID pipeline register and drives its pc, pc_plus_4, instruction and busywait inputs.
- Holds the PC register and a direct-mapped instruction cache: 8 lines, 4 words per line.
- On a miss, a fill FSM reads a 128-bit block from instruction memory.
- Branch redirect arrives from EX; hazard stall arrives from the ID hazard unit.

---
 rtl/rv32_pipeline_pkg.sv | 19 +
 rtl/if_stage_fetch_unit_pc_unit.sv | 28 ++
 rtl/if_stage_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_stage_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32IM pipeline definitions: NOP encoding, fetch FSM states, cache block geometry.
package rv32_pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int BLOCK_W = 128;
  localparam int WOFF_W  = 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  typedef logic [BLOCK_W-1:0] block_t;

  function automatic logic [31:0] block_word(input block_t blk, input logic [WOFF_W-1:0] off);
    return blk[{off, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/if_stage_fetch_unit_pc_unit.sv
// Fetch PC register with +4 adder and branch redirect mux; updates only when enabled.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4
);

  // Targets are word aligned; the low two bits carry no information.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign pc_plus_4 = pc + 32'd4;

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= branch_taken ? {branch_target[31:2], 2'b00} : pc_plus_4;
    end
  end

endmodule

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: PC plus direct-mapped read-only I-cache (4 words/line) with a
// block-fill FSM; hits return the instruction combinationally in the same cycle.
module if_stage_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          NUM_LINES = 8,
  parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic [31:0]  OUT_pc,
  output logic [31:0]  OUT_pc_plus_4,
  output logic [31:0]  OUT_instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [31:0]       pc;
  logic [31:0]       pc_plus_4;
  logic [WOFF_W-1:0] offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              miss_busy;
  logic              pc_en;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_array  [NUM_LINES];
  block_t               data_array [NUM_LINES];
  block_t               fill_buf;

  assign offset = pc[3:2];
  assign index  = pc[4 +: IDX_W];
  assign tag    = pc[31 -: TAG_W];
  assign hit    = valid[index] && (tag_array[index] == tag);

  // A miss that coincides with a redirect is abandoned: the new PC is fetched instead.
  always_comb begin
    next_state = state;
    miss_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (!hit && !branch_taken) begin
          miss_busy  = 1'b1;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        miss_busy = 1'b1;
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: begin
        miss_busy  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign pc_en = (state == IDLE) && !miss_busy && !stall && !reset;

  pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .CLK          (CLK),
    .reset        (reset),
    .en           (pc_en),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_plus_4    (pc_plus_4)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= next_state;
      if (state == UPDATE) valid[index] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if (!reset && state == MEM_READ && !mem_busywait) fill_buf <= mem_readdata;
    if (!reset && state == UPDATE) begin
      tag_array[index]  <= tag;
      data_array[index] <= fill_buf;
    end
  end

  assign OUT_pc          = reset ? RESET_PC : pc;
  assign OUT_pc_plus_4   = reset ? (RESET_PC + 32'd4) : pc_plus_4;
  assign busywait        = !reset && miss_busy;
  assign mem_read        = !reset && (state == MEM_READ);
  assign mem_address     = pc[31:4];
  assign OUT_instruction = (!reset && state == IDLE && hit) ? block_word(data_array[index], offset)
                                                           : NOP_INSTR;

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for the fetch stage; a 3-cycle block memory returns block 0 as a fixed
// program and every other block as its own byte addresses.
module tb_if_stage_fetch_unit;

  logic         CLK = 1'b0;
  logic         reset;
  logic         stall;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic [31:0]  OUT_pc;
  logic [31:0]  OUT_pc_plus_4;
  logic [31:0]  OUT_instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_total = 0;
  int n_bad   = 0;
  int mcnt    = 0;
  int n;
  logic [27:0] a;

  always #5 CLK = ~CLK;

  if_stage_fetch_unit dut (
    .CLK            (CLK),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .OUT_pc         (OUT_pc),
    .OUT_pc_plus_4  (OUT_pc_plus_4),
    .OUT_instruction(OUT_instruction),
    .busywait       (busywait),
    .mem_read       (mem_read),
    .mem_address    (mem_address),
    .mem_readdata   (mem_readdata),
    .mem_busywait   (mem_busywait)
  );

  function automatic logic [127:0] blk(input logic [27:0] ba);
    if (ba == 28'd0) return {32'h00000013, 32'h002081B3, 32'h00100113, 32'h00400093};
    return {ba, 4'hC, ba, 4'h8, ba, 4'h4, ba, 4'h0};
  endfunction

  // Read completes on the third cycle of mem_read.
  always @(posedge CLK) mcnt <= mem_read ? mcnt + 1 : 0;
  assign mem_busywait = mem_read && (mcnt < 2);
  assign mem_readdata = blk(mem_address);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_fill(output int cnt, output logic [27:0] addr);
    cnt  = 0;
    addr = 28'hDEADBEE;
    while (busywait && cnt < 40) begin
      if (mem_read) addr = mem_address;
      cnt++;
      step();
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    step();
    branch_taken  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    step();
    check_eq("rst_busywait", {31'd0, busywait}, 32'd0);
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_instr", OUT_instruction, 32'h00000013);
    check_eq("rst_pc", OUT_pc, 32'h00000000);
    check_eq("rst_pc4", OUT_pc_plus_4, 32'h00000004);
    step();

    // Cold miss at pc 0
    reset = 1'b0; #1;
    check_eq("cold_busy", {31'd0, busywait}, 32'd1);
    wait_fill(n, a);
    check_eq("cold_cycles", n, 5);
    check_eq("cold_addr", {4'd0, a}, 32'h0);
    check_eq("cold_pc0", OUT_pc, 32'h0);
    check_eq("cold_i0", OUT_instruction, 32'h00400093);
    step();
    check_eq("seq_pc4", OUT_pc, 32'h4);
    check_eq("seq_i4", OUT_instruction, 32'h00100113);
    check_eq("seq_busy4", {31'd0, busywait}, 32'd0);
    step();
    check_eq("seq_pc8", OUT_pc, 32'h8);
    check_eq("seq_i8", OUT_instruction, 32'h002081B3);

    // Stall on a hit at pc 8
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("stall_pc", OUT_pc, 32'h8);
      check_eq("stall_pc4", OUT_pc_plus_4, 32'hC);
      check_eq("stall_busy", {31'd0, busywait}, 32'd0);
    end
    stall = 1'b0;
    step();
    check_eq("seq_pcC", OUT_pc, 32'hC);
    check_eq("seq_iC", OUT_instruction, 32'h00000013);
    step();
    check_eq("seq_pc10", OUT_pc, 32'h10);

    // Branch while missing in IDLE: no fill, NOP presented
    branch_taken = 1'b1; branch_target = 32'h0; #1;
    check_eq("bmiss_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("bmiss_busy", {31'd0, busywait}, 32'd0);
    check_eq("bmiss_instr", OUT_instruction, 32'h00000013);
    step();
    branch_taken = 1'b0; #1;
    check_eq("bmiss_pc", OUT_pc, 32'h0);
    check_eq("bmiss_mem_read2", {31'd0, mem_read}, 32'd0);
    check_eq("bmiss_i0", OUT_instruction, 32'h00400093);

    // Conflict eviction on index 0
    redirect(32'h80);
    check_eq("evict_pc", OUT_pc, 32'h80);
    check_eq("evict_busy", {31'd0, busywait}, 32'd1);
    wait_fill(n, a);
    check_eq("evict_cycles", n, 5);
    check_eq("evict_addr", {4'd0, a}, 32'h8);
    check_eq("evict_instr", OUT_instruction, 32'h00000080);
    redirect(32'h0);
    check_eq("back_busy", {31'd0, busywait}, 32'd1);
    wait_fill(n, a);
    check_eq("back_addr", {4'd0, a}, 32'h0);
    check_eq("back_instr", OUT_instruction, 32'h00400093);

    // Branch raised during a fill is applied only after the hit cycle
    redirect(32'h20);
    check_eq("bfill_busy", {31'd0, busywait}, 32'd1);
    step();
    check_eq("bfill_mem_read", {31'd0, mem_read}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'h4; #1;
    wait_fill(n, a);
    check_eq("bfill_addr", {4'd0, a}, 32'h2);
    check_eq("bfill_pc_hold", OUT_pc, 32'h20);
    check_eq("bfill_hit", OUT_instruction, 32'h00000020);
    step();
    branch_taken = 1'b0; #1;
    check_eq("bfill_pc", OUT_pc, 32'h4);
    check_eq("bfill_i4", OUT_instruction, 32'h00100113);

    // Reset in the middle of a fill
    redirect(32'h30);
    step();
    check_eq("rfill_mem_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1; #1;
    check_eq("rfill_ovr_read", {31'd0, mem_read}, 32'd0);
    check_eq("rfill_ovr_busy", {31'd0, busywait}, 32'd0);
    check_eq("rfill_ovr_pc", OUT_pc, 32'h0);
    step();
    check_eq("rfill_mem_read2", {31'd0, mem_read}, 32'd0);
    check_eq("rfill_pc", OUT_pc, 32'h0);
    reset = 1'b0; #1;
    check_eq("rfill_cold", {31'd0, busywait}, 32'd1);
    wait_fill(n, a);
    check_eq("rfill_cycles", n, 5);
    check_eq("rfill_addr", {4'd0, a}, 32'h0);
    check_eq("rfill_i0", OUT_instruction, 32'h00400093);

    // Wrap-around at the top of the address space; target low bits ignored
    redirect(32'hFFFFFFFF);
    check_eq("wrap_pc", OUT_pc, 32'hFFFFFFFC);
    check_eq("wrap_busy", {31'd0, busywait}, 32'd1);
    wait_fill(n, a);
    check_eq("wrap_addr", {4'd0, a}, 32'h0FFFFFFF);
    check_eq("wrap_instr", OUT_instruction, 32'hFFFFFFFC);
    check_eq("wrap_pc4", OUT_pc_plus_4, 32'h0);
    step();
    check_eq("wrap_pc0", OUT_pc, 32'h0);
    check_eq("wrap_i0", OUT_instruction, 32'h00400093);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
